music_score_player: RTL and testbench
=====================================

Name: music_score_player

Overview:
- Upstream stage of the tone path. Walks a score ROM and produces the 5-bit note code `choose` (0 = rest, 1..21 = L1..H7) that feeds the note-to-period lookup and the PWM beeper.
- Each score entry holds a note and a duration in beat units.
- Supports play/pause, stop, optional looping, and an articulation gap of forced silence at the end of every note.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency.
- UNIT_HZ, 8, duration-unit rate. UNIT_CYC = CLK_HZ/UNIT_HZ clock cycles per unit.
- GAP_CYC, 120_000, silent cycles at the end of each note (10 ms). Must satisfy 0 <= GAP_CYC < UNIT_CYC.
- ADDR_W, 6, score address width.
- SCORE_LEN, 64, number of ROM entries, <= 2**ADDR_W.
- CNT_W, 24, note cycle counter width. Must hold 8*UNIT_CYC-1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- play, input, 1, level. 1 = run, 0 = pause.
- stop, input, 1, single-cycle pulse. Abort and return to the start of the score.
- loop_en, input, 1, level. 1 = restart from entry 0 at end of score.
- choose, output, 5, registered note code to the tone lookup.
- addr, output, ADDR_W, index of the entry currently sounding.
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, one-cycle pulse when the score ends with loop_en=0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, choose=0, addr=0, cnt=0, busy=0, done=0.
- Entry format: data[7:3]=note, data[2:0]=dur. Note length is (dur+1)*UNIT_CYC cycles. Note code 31 = END marker. Codes 22..30 are treated as rest (0).
- ROM read is combinational on addr; no fetch latency.
- States: IDLE, PLAY.
- IDLE:
  - choose=0.
  - When play=1 and stop=0: decode entry at addr.
  - Non-END entry → next edge: PLAY, cnt=0, choose=note. choose is valid one cycle after play is sampled high.
  - END entry → done pulse, stay IDLE, addr=0. No looping from IDLE, which prevents an infinite END loop.
- PLAY, play=1:
  - cnt increments every cycle. T = (dur+1)*UNIT_CYC.
  - choose = note while cnt < T-GAP_CYC; choose = 0 for the last GAP_CYC cycles. Registered: choose drops on the edge where cnt reaches T-GAP_CYC.
  - At cnt==T-1: next = addr+1.
  - If addr==SCORE_LEN-1 or entry(next) is END:
    - loop_en=1 → addr=0, load entry 0.
    - loop_en=0 → done=1 for one cycle, choose=0, addr=0, go IDLE.
  - Otherwise addr=next, cnt=0, choose=entry(next).note on the same edge. Note-to-note spacing is exactly T cycles with no dead cycles.
- PLAY, play=0 (pause):
  - cnt and addr freeze; choose=0 from the next edge.
  - When play returns to 1: choose restores the held note (or 0 if inside the gap) on the next edge, and counting resumes from the frozen cnt.
- stop:
  - Highest priority, any state.
  - Next edge: IDLE, choose=0, addr=0, cnt=0, busy=0, no done pulse.
  - stop and play high together in IDLE: stop wins; stay IDLE.
- loop_en is sampled only at the end-of-score decision.
- Reset mid-note: immediate silence (choose=0 asynchronously).

Decomposition:
- Shared package music_pkg:
  - NOTE_W=5, DUR_W=3.
  - NOTE_REST=5'd0, NOTE_END=5'd31.
  - Note code constants L1..H7 = 1..21, shared with the tone lookup.
  - Entry field positions.
- Sub-module music_score_rom:
  - Combinational case-based ROM, addr in, 8-bit data out.
  - The bench substitutes its own music_score_rom with test contents.

Test Plan (CLK_HZ=8, UNIT_HZ=2 → UNIT_CYC=4, GAP_CYC=1, SCORE_LEN=4; test ROM {8,d1},{12,d0},{0,d0},{31,x}):
- Basic play: raise play → choose=8 for 7 cycles, 0 for 1; then 12 for 3, 0 for 1; then 0 for 4; then done pulses for 1 cycle, busy=0, addr=0.
- Loop: loop_en=1 → after entry 2 ends, choose=8 immediately and addr=0; no done pulse across 3 full passes.
- Pause: drop play at cycle 3 of note 8 for 5 cycles → choose=0 during pause. After resume, choose=8 for the remaining 4 cycles, then the gap; total note-8 sounding cycles = 7.
- Stop mid-score: stop pulse during entry 1 → next cycle choose=0, addr=0, busy=0, no done. Re-raising play restarts at entry 0.
- Async reset: assert rst_n=0 mid-gap of entry 0 → choose=0, addr=0, busy=0 without a clock edge. Release → IDLE.
- END at entry 0 (alternate ROM): play=1 → single done pulse, stays IDLE, choose stays 0, even with loop_en=1.

Source files
------------

// File: rtl/music_pkg.sv
// Shared score-entry format and note codes for the tone path
// (score player, note-to-period lookup, beeper).
package music_pkg;

  localparam int NOTE_W   = 5;
  localparam int DUR_W    = 3;
  localparam int ENTRY_W  = NOTE_W + DUR_W;
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 5'd31;

  localparam logic [NOTE_W-1:0] L1 = 5'd1;
  localparam logic [NOTE_W-1:0] L2 = 5'd2;
  localparam logic [NOTE_W-1:0] L3 = 5'd3;
  localparam logic [NOTE_W-1:0] L4 = 5'd4;
  localparam logic [NOTE_W-1:0] L5 = 5'd5;
  localparam logic [NOTE_W-1:0] L6 = 5'd6;
  localparam logic [NOTE_W-1:0] L7 = 5'd7;
  localparam logic [NOTE_W-1:0] M1 = 5'd8;
  localparam logic [NOTE_W-1:0] M2 = 5'd9;
  localparam logic [NOTE_W-1:0] M3 = 5'd10;
  localparam logic [NOTE_W-1:0] M4 = 5'd11;
  localparam logic [NOTE_W-1:0] M5 = 5'd12;
  localparam logic [NOTE_W-1:0] M6 = 5'd13;
  localparam logic [NOTE_W-1:0] M7 = 5'd14;
  localparam logic [NOTE_W-1:0] H1 = 5'd15;
  localparam logic [NOTE_W-1:0] H2 = 5'd16;
  localparam logic [NOTE_W-1:0] H3 = 5'd17;
  localparam logic [NOTE_W-1:0] H4 = 5'd18;
  localparam logic [NOTE_W-1:0] H5 = 5'd19;
  localparam logic [NOTE_W-1:0] H6 = 5'd20;
  localparam logic [NOTE_W-1:0] H7 = 5'd21;

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  function automatic logic entry_is_end(input logic [ENTRY_W-1:0] e);
    return e[NOTE_MSB:NOTE_LSB] == NOTE_END;
  endfunction

  // Unassigned codes (above H7, including END) sound as rest.
  function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] e);
    logic [NOTE_W-1:0] raw;
    raw = e[NOTE_MSB:NOTE_LSB];
    return (raw > H7) ? NOTE_REST : raw;
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/music_score_rom.sv
// Combinational score ROM. VARIANT selects the built-in score:
// 0 = production tune, 1 = short test score, 2 = END at entry 0.
module music_score_rom
  import music_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int VARIANT = 0
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  always_comb begin
    data_o = {NOTE_END, 3'd0};
    if (VARIANT == 1) begin
      case (int'(addr_i))
        0:       data_o = {M1, 3'd1};
        1:       data_o = {M5, 3'd0};
        2:       data_o = {NOTE_REST, 3'd0};
        default: data_o = {NOTE_END, 3'd0};
      endcase
    end else if (VARIANT == 2) begin
      case (int'(addr_i))
        0:       data_o = {NOTE_END, 3'd0};
        1:       data_o = {M5, 3'd1};
        default: data_o = {NOTE_END, 3'd0};
      endcase
    end else begin
      case (int'(addr_i))
        0:       data_o = {M1, 3'd1};
        1:       data_o = {M1, 3'd1};
        2:       data_o = {M5, 3'd1};
        3:       data_o = {M5, 3'd1};
        4:       data_o = {M6, 3'd1};
        5:       data_o = {M6, 3'd1};
        6:       data_o = {M5, 3'd3};
        7:       data_o = {M4, 3'd1};
        8:       data_o = {M4, 3'd1};
        9:       data_o = {M3, 3'd1};
        10:      data_o = {M3, 3'd1};
        11:      data_o = {M2, 3'd1};
        12:      data_o = {M2, 3'd1};
        13:      data_o = {M1, 3'd3};
        14:      data_o = {NOTE_REST, 3'd3};
        default: data_o = {NOTE_END, 3'd0};
      endcase
    end
  end

endmodule

// File: rtl/music_score_player.sv
// Walks the score ROM and drives the registered note code `choose`,
// with play/pause, stop, optional looping and an end-of-note silence gap.
module music_score_player
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int UNIT_HZ     = 8,
  parameter int GAP_CYC     = 120_000,
  parameter int ADDR_W      = 6,
  parameter int SCORE_LEN   = 64,
  parameter int CNT_W       = 24,
  parameter int ROM_VARIANT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  output logic [NOTE_W-1:0] choose,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0]  UNIT_CYC  = CNT_W'(CLK_HZ / UNIT_HZ);
  localparam logic [CNT_W-1:0]  GAP_LEN   = CNT_W'(GAP_CYC);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCORE_LEN - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NOTE_W-1:0]   choose_q, choose_d;
  logic                done_q, done_d;

  logic [ENTRY_W-1:0]  cur_entry, nxt_entry, first_entry;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [CNT_W-1:0]    note_len, cnt_inc;
  logic                score_over;

  assign nxt_addr = addr_q + ADDR_W'(1);

  // Separate read ports for the current, following and first entries so a
  // note change (or loop restart) loads the new note on the same edge.
  music_score_rom #(.ADDR_W(ADDR_W), .VARIANT(ROM_VARIANT)) u_rom_cur (
    .addr_i (addr_q),
    .data_o (cur_entry)
  );

  music_score_rom #(.ADDR_W(ADDR_W), .VARIANT(ROM_VARIANT)) u_rom_nxt (
    .addr_i (nxt_addr),
    .data_o (nxt_entry)
  );

  music_score_rom #(.ADDR_W(ADDR_W), .VARIANT(ROM_VARIANT)) u_rom_first (
    .addr_i ('0),
    .data_o (first_entry)
  );

  assign note_len   = (CNT_W'(entry_dur(cur_entry)) + CNT_W'(1)) * UNIT_CYC;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign score_over = (addr_q == LAST_ADDR) || entry_is_end(nxt_entry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      choose_q <= NOTE_REST;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      choose_q <= choose_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    choose_d = choose_q;
    done_d   = 1'b0;
    if (stop) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      cnt_d    = '0;
      choose_d = NOTE_REST;
    end else begin
      case (state_q)
        S_IDLE: begin
          choose_d = NOTE_REST;
          if (play) begin
            if (entry_is_end(cur_entry)) begin
              done_d = 1'b1;
              addr_d = '0;
            end else begin
              state_d  = S_PLAY;
              cnt_d    = '0;
              choose_d = entry_note(cur_entry);
            end
          end
        end
        S_PLAY: begin
          if (!play) begin
            choose_d = NOTE_REST;
          end else if (cnt_q == note_len - CNT_W'(1)) begin
            cnt_d = '0;
            if (!score_over) begin
              addr_d   = nxt_addr;
              choose_d = entry_note(nxt_entry);
            end else if (loop_en && !entry_is_end(first_entry)) begin
              addr_d   = '0;
              choose_d = entry_note(first_entry);
            end else begin
              state_d  = S_IDLE;
              addr_d   = '0;
              choose_d = NOTE_REST;
              done_d   = 1'b1;
            end
          end else begin
            // choose tracks the count it will sit beside after this edge.
            cnt_d    = cnt_inc;
            choose_d = (cnt_inc < note_len - GAP_LEN) ? entry_note(cur_entry) : NOTE_REST;
          end
        end
        default: begin
          state_d  = S_IDLE;
          addr_d   = '0;
          cnt_d    = '0;
          choose_d = NOTE_REST;
        end
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    choose = choose_q;
    addr   = addr_q;
    done   = done_q;
  end

endmodule

// File: tb/tb_music_score_player.sv
// Bench for music_score_player: two instances (test score, END-first score)
// checked every cycle against a position-in-score reference model.
module tb_music_score_player;

  localparam int UNIT = 4;
  localparam int GAP  = 1;
  localparam int LEN  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play_a = 1'b0, stop_a = 1'b0, loop_a = 1'b0;
  logic       play_b = 1'b0, stop_b = 1'b0, loop_b = 1'b0;
  logic [4:0] choose_a, choose_b;
  logic [1:0] addr_a, addr_b;
  logic       busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  music_score_player #(
    .CLK_HZ(8), .UNIT_HZ(2), .GAP_CYC(GAP), .ADDR_W(2),
    .SCORE_LEN(LEN), .CNT_W(8), .ROM_VARIANT(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .play(play_a), .stop(stop_a), .loop_en(loop_a),
    .choose(choose_a), .addr(addr_a), .busy(busy_a), .done(done_a)
  );

  music_score_player #(
    .CLK_HZ(8), .UNIT_HZ(2), .GAP_CYC(GAP), .ADDR_W(2),
    .SCORE_LEN(LEN), .CNT_W(8), .ROM_VARIANT(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .play(play_b), .stop(stop_b), .loop_en(loop_b),
    .choose(choose_b), .addr(addr_b), .busy(busy_b), .done(done_b)
  );

  int nchk = 0;
  int nerr = 0;
  int snd8 = 0;
  int dn_a = 0;
  int dn_b = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each instance is "busy or not", which entry, how many
  // cycles into that entry, and whether play was high at the last edge.
  logic [7:0] score [2][LEN];
  bit         m_busy [2];
  bit         m_pl   [2];
  bit         m_done [2];
  int         m_addr [2];
  int         m_el   [2];

  function automatic int len_of(input logic [7:0] e);
    return (int'(e[2:0]) + 1) * UNIT;
  endfunction

  function automatic int note_of(input logic [7:0] e);
    return (int'(e[7:3]) > 21) ? 0 : int'(e[7:3]);
  endfunction

  function automatic bit is_end(input logic [7:0] e);
    return e[7:3] == 5'd31;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pl[k] = 0; m_done[k] = 0; m_addr[k] = 0; m_el[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit p, input bit s, input bit l);
    m_done[k] = 0;
    if (s) begin
      m_busy[k] = 0; m_addr[k] = 0; m_el[k] = 0;
    end else if (!m_busy[k]) begin
      if (p) begin
        if (is_end(score[k][m_addr[k]])) m_done[k] = 1;
        else begin m_busy[k] = 1; m_el[k] = 0; end
      end
    end else if (p) begin
      m_el[k]++;
      if (m_el[k] == len_of(score[k][m_addr[k]])) begin
        m_el[k] = 0;
        if (m_addr[k] + 1 == LEN || is_end(score[k][m_addr[k] + 1])) begin
          m_addr[k] = 0;
          if (!l) begin m_busy[k] = 0; m_done[k] = 1; end
        end else begin
          m_addr[k]++;
        end
      end
    end
    m_pl[k] = p;
  endtask

  function automatic int exp_choose(input int k);
    logic [7:0] e;
    e = score[k][m_addr[k]];
    if (m_busy[k] && m_pl[k] && m_el[k] < len_of(e) - GAP) return note_of(e);
    return 0;
  endfunction

  task automatic check_outputs();
    check_eq("a_choose", int'(choose_a), exp_choose(0));
    check_eq("a_addr",   int'(addr_a),   m_addr[0]);
    check_eq("a_busy",   int'(busy_a),   int'(m_busy[0]));
    check_eq("a_done",   int'(done_a),   int'(m_done[0]));
    check_eq("b_choose", int'(choose_b), exp_choose(1));
    check_eq("b_addr",   int'(addr_b),   m_addr[1]);
    check_eq("b_busy",   int'(busy_b),   int'(m_busy[1]));
    check_eq("b_done",   int'(done_b),   int'(m_done[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, play_a, stop_a, loop_a);
    model_step(1, play_b, stop_b, loop_b);
    #1;
    check_outputs();
    if (choose_a == 5'd8) snd8++;
    if (done_a) dn_a++;
    if (done_b) dn_b++;
  endtask

  // Reset lands between edges so the check sees its asynchronous effect.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("areset_choose", int'(choose_a), 0);
    check_eq("areset_addr",   int'(addr_a),   0);
    check_eq("areset_busy",   int'(busy_a),   0);
    check_outputs();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    score[0][0] = {5'd8, 3'd1};
    score[0][1] = {5'd12, 3'd0};
    score[0][2] = {5'd0, 3'd0};
    score[0][3] = {5'd31, 3'd0};
    score[1][0] = {5'd31, 3'd0};
    score[1][1] = {5'd12, 3'd1};
    score[1][2] = {5'd31, 3'd0};
    score[1][3] = {5'd31, 3'd0};
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // END at entry 0: a single play request gives one done, never plays.
    dn_b = 0; play_b = 1'b1; loop_b = 1'b1;
    tick();
    play_b = 1'b0;
    repeat (3) tick();
    check_eq("endfirst_done_pulses", dn_b, 1);
    loop_b = 1'b0;

    // Basic play-through to a single done pulse.
    dn_a = 0; play_a = 1'b1;
    repeat (17) tick();
    play_a = 1'b0;
    tick();
    check_eq("basic_done_pulses", dn_a, 1);

    // Three full looped passes without a done pulse.
    dn_a = 0; loop_a = 1'b1; play_a = 1'b1;
    repeat (48) tick();
    check_eq("loop_done_pulses", dn_a, 0);
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0; play_a = 1'b0; loop_a = 1'b0;
    tick();

    // Pause three cycles into note 8 for five cycles.
    snd8 = 0; play_a = 1'b1;
    repeat (3) tick();
    play_a = 1'b0;
    repeat (5) tick();
    play_a = 1'b1;
    repeat (14) tick();
    play_a = 1'b0;
    tick();
    check_eq("pause_note8_cycles", snd8, 7);

    // Stop during entry 1, restart, then stop+play together from IDLE.
    dn_a = 0; play_a = 1'b1;
    repeat (10) tick();
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    check_eq("stop_busy", int'(busy_a), 0);
    check_eq("stop_done_pulses", dn_a, 0);
    repeat (2) tick();
    check_eq("restart_choose", int'(choose_a), 8);
    stop_a = 1'b1;
    repeat (2) tick();
    check_eq("stop_play_idle", int'(busy_a), 0);
    stop_a = 1'b0; play_a = 1'b0;
    tick();

    // Async reset inside the gap of entry 0.
    play_a = 1'b1;
    repeat (8) tick();
    async_reset();
    play_a = 1'b0;
    tick();

    // Randomized traffic on both instances.
    repeat (600) begin
      play_a = ($urandom_range(0, 9) < 8);
      stop_a = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) loop_a = ~loop_a;
      play_b = ($urandom_range(0, 3) == 0);
      stop_b = ($urandom_range(0, 19) == 0);
      loop_b = $urandom_range(0, 1) == 1;
      tick();
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
